// File: rtl/interrupt_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
package interrupt_arbiter_pkg;

  localparam int unsigned NUM_SRC = 4;

  // Register offsets within the 4-byte window
  localparam logic [1:0] OffMask    = 2'd0;
  localparam logic [1:0] OffPending = 2'd1;
  localparam logic [1:0] OffVector  = 2'd2;
  localparam logic [1:0] OffEoi     = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StInService
  } state_e;

endpackage

// File: rtl/interrupt_arbiter_if.sv
// CPU bus and interrupt handshake bundle for the interrupt arbiter.
// The shared data bus is resolved here: the arbiter drives it only while a
// read response is valid, the CPU side only while it is writing.
interface interrupt_arbiter_if;

  logic [7:0] bus_addr;
  logic       bus_we;
  logic [7:0] cpu_wdata;
  logic       cpu_oe;
  logic [7:0] rd_data;
  logic       rd_oe;
  wire  [7:0] bus_data;
  logic [3:0] src_raise;
  logic [3:0] src_ack;
  logic       cpu_int_raise;
  logic       cpu_int_ack;

  assign bus_data = rd_oe ? rd_data : (cpu_oe ? cpu_wdata : 8'hzz);

  modport master (
    output bus_addr, bus_we, cpu_wdata, cpu_oe, src_raise, cpu_int_ack,
    input  bus_data, rd_oe, src_ack, cpu_int_raise
  );

  modport slave (
    input  bus_addr, bus_we, bus_data, src_raise, cpu_int_ack,
    output rd_data, rd_oe, src_ack, cpu_int_raise
  );

endinterface

// File: rtl/interrupt_arbiter_rr_picker.sv
// Combinational round-robin selector: first request found scanning upward
// from the slot after the last one served, wrapping mod 4.
module rr_picker (
  input  logic [3:0] request_i,
  input  logic [1:0] last_i,
  output logic       valid_o,
  output logic [1:0] grant_o
);

  logic [1:0] idx;

  // Scan last+1 .. last+4; the first hit wins.
  always_comb begin
    valid_o = 1'b0;
    grant_o = 2'd0;
    idx     = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_i + 2'(i);
      if (!valid_o && request_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: latches rising-edge requests from four peripherals,
// grants one at a time to the CPU round-robin and exposes a small register
// window (MASK, PENDING, VECTOR, EOI) on the shared CPU bus.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hC0,
  parameter int unsigned NUM_SRC   = interrupt_arbiter_pkg::NUM_SRC
) (
  input logic               clk_i,
  input logic               rst_ni,
  interrupt_arbiter_if.slave bus
);

  state_e             state_q;
  logic [NUM_SRC-1:0] mask_q, pending_q, src_prev_q, ack_q;
  logic [1:0]         vec_q, last_q;
  logic               in_svc_q, raise_q, rd_oe_q;
  logic [7:0]         rd_data_q;

  logic [7:0]         offset, wdata, rd_val;
  logic               in_win, wr_hit, rd_hit;
  logic [NUM_SRC-1:0] rise, w1c_clr, ack_clr, pending_d, eligible;
  logic               pick_valid;
  logic [1:0]         pick_grant;
  logic               unused_wdata;

  // Address decode and pending next-state; a new edge beats either clear.
  always_comb begin
    offset    = bus.bus_addr - BASE_ADDR;
    in_win    = (offset[7:2] == 6'd0);
    wr_hit    = in_win & bus.bus_we;
    rd_hit    = in_win & ~bus.bus_we;
    wdata     = bus.bus_data;
    rise      = bus.src_raise & ~src_prev_q;
    w1c_clr   = (wr_hit && offset[1:0] == OffPending) ? wdata[NUM_SRC-1:0] : '0;
    ack_clr   = (state_q == StWaitAck && bus.cpu_int_ack) ? (NUM_SRC'(1) << vec_q) : '0;
    pending_d = (pending_q & ~w1c_clr & ~ack_clr) | rise;
    eligible  = pending_q & mask_q;
  end

  // Read data mux for the register window.
  always_comb begin
    rd_val = 8'h00;
    unique case (offset[1:0])
      OffMask:    rd_val = 8'(mask_q);
      OffPending: rd_val = 8'(pending_q);
      OffVector:  rd_val = {in_svc_q, 5'd0, vec_q};
      OffEoi:     rd_val = 8'h00;
      default:    rd_val = 8'h00;
    endcase
  end

  rr_picker u_rr_picker (
    .request_i (eligible),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .grant_o   (pick_grant)
  );

  // Grant FSM, register window and bus read response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
      ack_q      <= '0;
      vec_q      <= 2'd0;
      last_q     <= 2'd3;
      in_svc_q   <= 1'b0;
      raise_q    <= 1'b0;
      rd_oe_q    <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      src_prev_q <= bus.src_raise;
      pending_q  <= pending_d;
      ack_q      <= '0;
      rd_oe_q    <= rd_hit;
      if (rd_hit) rd_data_q <= rd_val;
      if (wr_hit && offset[1:0] == OffMask) mask_q <= wdata[NUM_SRC-1:0];
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            vec_q   <= pick_grant;
            raise_q <= 1'b1;
            state_q <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (bus.cpu_int_ack) begin
            raise_q  <= 1'b0;
            ack_q    <= NUM_SRC'(1) << vec_q;
            in_svc_q <= 1'b1;
            state_q  <= StInService;
          end
        end
        StInService: begin
          if (wr_hit && offset[1:0] == OffEoi) begin
            last_q   <= vec_q;
            in_svc_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.src_ack       = ack_q;
  assign bus.cpu_int_raise = raise_q;
  assign bus.rd_oe         = rd_oe_q;
  assign bus.rd_data       = rd_data_q;

  // EOI takes any value and MASK/PENDING use only the low bits.
  assign unused_wdata = ^wdata[7:NUM_SRC];

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter; register reads are checked through a
// scoreboard queue filled when each read is issued.
module tb_interrupt_arbiter;

  localparam logic [7:0] Base = 8'hC0;

  logic clk;
  logic rst_ni;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;
  exp_t sb_q[$];

  interrupt_arbiter_if bus_if ();

  interrupt_arbiter #(
    .BASE_ADDR (Base),
    .NUM_SRC   (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] data);
    bus_if.bus_addr  = Base + 8'(off);
    bus_if.bus_we    = 1'b1;
    bus_if.cpu_wdata = data;
    bus_if.cpu_oe    = 1'b1;
    tick();
    bus_if.bus_we    = 1'b0;
    bus_if.cpu_oe    = 1'b0;
    bus_if.bus_addr  = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] off, input string tag, input logic [7:0] exp);
    exp_t e;
    sb_q.push_back('{tag: tag, exp: exp});
    bus_if.bus_addr = Base + 8'(off);
    bus_if.bus_we   = 1'b0;
    tick();
    bus_if.bus_addr = 8'h00;
    chk({tag, "_oe"}, 8'(bus_if.rd_oe), 8'h01);
    e = sb_q.pop_front();
    chk(e.tag, bus_if.bus_data, e.exp);
    tick();
    chk({tag, "_release"}, 8'(bus_if.rd_oe), 8'h00);
  endtask

  // SRC_ACK must never have more than one bit set.
  always @(negedge clk) begin
    n_vec++;
    assert ($onehot0(bus_if.src_ack)) else begin
      n_err++;
      $error("FAIL ack_onehot: observed %b expected one-hot or zero", bus_if.src_ack);
    end
  end

  initial begin
    rst_ni             = 1'b0;
    bus_if.bus_addr    = 8'h00;
    bus_if.bus_we      = 1'b0;
    bus_if.cpu_wdata   = 8'h00;
    bus_if.cpu_oe      = 1'b0;
    bus_if.src_raise   = 4'h0;
    bus_if.cpu_int_ack = 1'b0;
    repeat (2) tick();
    chk("rst_raise", 8'(bus_if.cpu_int_raise), 8'h00);
    chk("rst_ack", 8'(bus_if.src_ack), 8'h00);
    chk("rst_oe", 8'(bus_if.rd_oe), 8'h00);
    rst_ni = 1'b1;
    tick();
    bus_read(2'd0, "rst_mask", 8'h00);
    bus_read(2'd1, "rst_pending", 8'h00);
    bus_read(2'd2, "rst_vector", 8'h00);

    // Single source 2: raise two cycles after its edge, ack pulse, vector.
    bus_write(2'd0, 8'h0F);
    bus_if.src_raise = 4'b0100;
    tick();
    chk("a_raise_early", 8'(bus_if.cpu_int_raise), 8'h00);
    tick();
    chk("a_raise", 8'(bus_if.cpu_int_raise), 8'h01);
    tick();
    chk("a_raise_hold", 8'(bus_if.cpu_int_raise), 8'h01);
    chk("a_no_ack_yet", 8'(bus_if.src_ack), 8'h00);
    bus_if.cpu_int_ack = 1'b1;
    tick();
    bus_if.cpu_int_ack = 1'b0;
    chk("a_raise_drop", 8'(bus_if.cpu_int_raise), 8'h00);
    chk("a_src_ack", 8'(bus_if.src_ack), 8'h04);
    tick();
    chk("a_src_ack_1cyc", 8'(bus_if.src_ack), 8'h00);
    bus_read(2'd2, "a_vector", 8'h82);
    bus_read(2'd1, "a_pending", 8'h00);
    bus_if.src_raise = 4'b0000;
    bus_write(2'd3, 8'h5A);
    bus_read(2'd2, "a_vector_eoi", 8'h02);

    // Source 0 held high through ack and EOI gets exactly one grant.
    bus_if.src_raise = 4'b0001;
    repeat (2) tick();
    chk("h_raise", 8'(bus_if.cpu_int_raise), 8'h01);
    bus_if.cpu_int_ack = 1'b1;
    tick();
    bus_if.cpu_int_ack = 1'b0;
    chk("h_src_ack", 8'(bus_if.src_ack), 8'h01);
    bus_write(2'd3, 8'h00);
    repeat (4) tick();
    chk("h_no_regrant", 8'(bus_if.cpu_int_raise), 8'h00);
    bus_read(2'd1, "h_pending", 8'h00);
    bus_if.src_raise = 4'b0000;
    tick();

    // LAST=0, sources 0 and 3 together: 3 first, then 0 after EOI.
    bus_if.src_raise = 4'b1001;
    repeat (2) tick();
    chk("b_raise", 8'(bus_if.cpu_int_raise), 8'h01);
    bus_read(2'd2, "b_vector_first", 8'h03);
    bus_if.cpu_int_ack = 1'b1;
    tick();
    bus_if.cpu_int_ack = 1'b0;
    chk("b_src_ack_first", 8'(bus_if.src_ack), 8'h08);
    bus_write(2'd3, 8'h00);
    chk("b_eoi_gap", 8'(bus_if.cpu_int_raise), 8'h00);
    tick();
    chk("b_raise_second", 8'(bus_if.cpu_int_raise), 8'h01);
    bus_if.cpu_int_ack = 1'b1;
    tick();
    bus_if.cpu_int_ack = 1'b0;
    chk("b_src_ack_second", 8'(bus_if.src_ack), 8'h01);
    bus_write(2'd3, 8'h00);
    bus_if.src_raise = 4'b0000;
    tick();

    // Masked source still latches pending; unmasking grants it.
    bus_write(2'd0, 8'h00);
    bus_if.src_raise = 4'b0010;
    repeat (3) tick();
    chk("c_masked_raise", 8'(bus_if.cpu_int_raise), 8'h00);
    bus_read(2'd1, "c_pending", 8'h02);
    bus_write(2'd0, 8'h02);
    tick();
    chk("c_raise", 8'(bus_if.cpu_int_raise), 8'h01);
    bus_if.cpu_int_ack = 1'b1;
    tick();
    bus_if.cpu_int_ack = 1'b0;
    chk("c_src_ack", 8'(bus_if.src_ack), 8'h02);
    bus_write(2'd3, 8'h00);
    bus_if.src_raise = 4'b0000;
    tick();

    // Edge and W1C on the same bit in the same cycle: set wins.
    bus_write(2'd0, 8'h00);
    bus_if.src_raise = 4'b0010;
    bus_write(2'd1, 8'h02);
    bus_read(2'd1, "d_set_wins", 8'h02);
    bus_write(2'd1, 8'h02);
    bus_read(2'd1, "d_w1c", 8'h00);
    bus_write(2'd2, 8'hFF);
    bus_read(2'd2, "d_vector_ro", 8'h01);
    bus_if.src_raise = 4'b0000;
    tick();

    // Reset during WAIT_ACK drops the request at once, no ack pulse.
    bus_write(2'd0, 8'h0F);
    bus_if.src_raise = 4'b0100;
    repeat (2) tick();
    chk("e_raise", 8'(bus_if.cpu_int_raise), 8'h01);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("e_raise_async", 8'(bus_if.cpu_int_raise), 8'h00);
    chk("e_ack_async", 8'(bus_if.src_ack), 8'h00);
    bus_if.cpu_int_ack = 1'b1;
    tick();
    chk("e_no_ack", 8'(bus_if.src_ack), 8'h00);
    bus_if.cpu_int_ack = 1'b0;
    bus_if.src_raise   = 4'b0000;
    rst_ni             = 1'b1;
    tick();
    chk("e_no_ack_after", 8'(bus_if.src_ack), 8'h00);
    bus_read(2'd0, "e_mask", 8'h00);
    bus_read(2'd1, "e_pending", 8'h00);
    bus_read(2'd2, "e_vector", 8'h00);

    chk("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 8'hC0: base of the 4-byte register window (BASE_ADDR..BASE_ADDR+3).
REQ-002 Parameter NUM_SRC, default 4: number of peripheral interrupt sources; fixed at 4 for this revision.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 BUS_DATA  inout  8  shared CPU data bus; driven only during a read of this block, else high-Z.
REQ-006 BUS_ADDR  input  8  shared CPU address bus.
REQ-007 BUS_WE  input  1  bus write enable.
REQ-008 SRC_RAISE  input  4  per-source interrupt request from peripherals (held high until acknowledged).
REQ-009 SRC_ACK  output  4  per-source acknowledge, one-cycle pulse.
REQ-010 CPU_INT_RAISE  output  1  merged interrupt request to the CPU.
REQ-011 CPU_INT_ACK  input  1  CPU acknowledge of CPU_INT_RAISE.

Function
REQ-012 Register map: +0 MASK (RW, bit i=1 enables source i); +1 PENDING (R; write 1 to clear bit); +2 VECTOR (R, bits[1:0] = granted source, bit7 = in-service flag); +3 EOI (W, any value ends service).
REQ-013 PENDING[i] SHALL set on a rising edge of SRC_RAISE[i] (previous-cycle sample 0, current 1); level alone SHALL NOT re-set it.
REQ-014 Masked sources SHALL still latch PENDING but SHALL NOT be selected.
REQ-015 FSM states IDLE, WAIT_ACK, IN_SERVICE.
REQ-016 IDLE: if (PENDING & MASK) != 0, select a source round-robin starting at (LAST+1) mod 4, latch VECTOR, assert CPU_INT_RAISE next cycle, go WAIT_ACK.
REQ-017 WAIT_ACK: hold CPU_INT_RAISE high; on CPU_INT_ACK=1, deassert CPU_INT_RAISE, pulse SRC_ACK[VECTOR] for exactly one cycle, clear PENDING[VECTOR], go IN_SERVICE.
REQ-018 IN_SERVICE: no new grant; on bus write to +3, set LAST = VECTOR, clear in-service flag, go IDLE; earliest next CPU_INT_RAISE is 2 cycles after EOI write.
REQ-019 MASK changes during WAIT_ACK or IN_SERVICE SHALL NOT cancel the current grant.
REQ-020 Simultaneous PENDING set (edge) and clear (ack or W1C) on the same bit, same cycle: set wins.
REQ-021 Writes to +1 with bit i=1 clear PENDING[i]; writes to +2 are ignored; EOI outside IN_SERVICE is ignored.
REQ-022 Write: on rising edge with BUS_WE=1 and BUS_ADDR in window, register updated that edge.
REQ-023 Read: on rising edge with BUS_WE=0 and BUS_ADDR in window, data latched; BUS_DATA driven with it for the following cycle only, high-Z otherwise.
REQ-024 SRC_ACK SHALL be one-hot or zero at all times.

Reset
REQ-025 RESET low asynchronously forces: state IDLE, MASK=0, PENDING=0, VECTOR=0, LAST=3 (so source 0 wins first), CPU_INT_RAISE=0, SRC_ACK=0, BUS_DATA high-Z, edge-detect samples=0.
REQ-026 Reset mid-WAIT_ACK SHALL drop CPU_INT_RAISE immediately with no SRC_ACK pulse.

Structure
REQ-027 Package interrupt_arbiter_pkg holds the state enum, register offsets (0..3) and NUM_SRC.
REQ-028 One sub-module, rr_picker: combinational round-robin selector (request[3:0], last[1:0] -> valid, grant[1:0]).

Verification
REQ-029 MASK=4'hF; SRC_RAISE[2] rises -> CPU_INT_RAISE high 2 cycles later; ack -> SRC_ACK=4'b0100 for one cycle, VECTOR reads 8'h82.
REQ-030 MASK=4'hF, sources 0 and 3 rise together, LAST=0 -> source 3 granted first; after EOI, source 0 granted.
REQ-031 MASK=4'h0, SRC_RAISE[1] rises -> PENDING reads 8'h02, CPU_INT_RAISE stays 0; write MASK=8'h02 -> grant of source 1.
REQ-032 SRC_RAISE[1] rising edge in same cycle as W1C of bit 1 -> PENDING[1]=1 after.
REQ-033 Hold SRC_RAISE[0] high through ack and EOI -> no second grant for source 0.
REQ-034 Assert RESET low during WAIT_ACK -> CPU_INT_RAISE=0 same cycle, all registers read 0, no SRC_ACK pulse.
